// File: rtl/score_accum.sv
// Multi-source BCD score accumulator: round-robin add requests, digit-serial
// BCD addition into per-player scores, with high score, saturation and extra-life pulses.
module score_accum #(
  parameter int NUM_SRC    = 3,
  parameter int DIGITS     = 5,
  parameter int PLAYERS    = 2,
  parameter int LIFE_DIGIT = 4,
  localparam int PSEL_W    = (PLAYERS > 1) ? $clog2(PLAYERS) : 1
) (
  input  logic                                   clk,
  input  logic                                   resetN,
  input  logic [NUM_SRC-1:0]                     add_valid,
  input  logic [NUM_SRC-1:0][DIGITS-1:0][3:0]    add_value,
  input  logic [NUM_SRC-1:0][PSEL_W-1:0]         add_player,
  output logic [NUM_SRC-1:0]                     add_ready,
  input  logic                                   clear,
  input  logic                                   hiscore_clr,
  output logic [PLAYERS-1:0][DIGITS-1:0][3:0]    score,
  output logic [DIGITS-1:0][3:0]                 hiscore,
  output logic [PLAYERS-1:0]                     overflow,
  output logic [PLAYERS-1:0]                     extra_life,
  output logic                                   busy
);

  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int K_W   = $clog2(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_COMMIT} state_t;

  state_t                              r_state;
  state_t                              w_state_next;
  logic [SRC_W-1:0]                    r_rr;
  logic [DIGITS-1:0][3:0]              r_op;
  logic [PSEL_W-1:0]                   r_player;
  logic [K_W-1:0]                      r_k;
  logic                                r_carry;
  logic [DIGITS-1:0][3:0]              r_work;
  logic [PLAYERS-1:0][DIGITS-1:0][3:0] r_score;
  logic [DIGITS-1:0][3:0]              r_hiscore;
  logic [PLAYERS-1:0]                  r_overflow;
  logic [PLAYERS-1:0]                  r_life;

  logic                                w_found;
  logic [SRC_W-1:0]                    w_gidx;
  logic [SRC_W-1:0]                    w_cand;
  logic [SRC_W:0]                      w_tmp;
  logic [SRC_W:0]                      w_rr_sum;
  logic [SRC_W-1:0]                    w_rr_next;
  logic                                w_accept;
  logic                                w_pvalid;
  logic [DIGITS-1:0][3:0]              w_cur;
  logic [3:0]                          w_opd;
  logic [4:0]                          w_sum;
  logic [3:0]                          w_digit;
  logic                                w_cout;
  logic [DIGITS-1:0][3:0]              w_new;
  logic                                w_life;
  logic                                w_gt;

  // Round-robin search: first valid source at or after the pointer.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_cand  = '0;
    w_tmp   = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      w_tmp = {1'b0, r_rr} + (SRC_W+1)'(off);
      if (w_tmp >= (SRC_W+1)'(NUM_SRC)) begin
        w_tmp = w_tmp - (SRC_W+1)'(NUM_SRC);
      end
      w_cand = w_tmp[SRC_W-1:0];
      if (!w_found && add_valid[w_cand]) begin
        w_found = 1'b1;
        w_gidx  = w_cand;
      end
    end
  end

  always_comb begin
    w_accept  = (r_state == S_IDLE) && !clear && w_found;
    add_ready = w_accept ? (NUM_SRC'(1) << w_gidx) : '0;
    w_rr_sum  = {1'b0, w_gidx} + (SRC_W+1)'(1);
    w_rr_next = (w_rr_sum >= (SRC_W+1)'(NUM_SRC)) ? '0 : w_rr_sum[SRC_W-1:0];
  end

  // Digit-serial BCD adder; an out-of-range player reads as zero and is never written.
  always_comb begin
    w_pvalid = ({1'b0, r_player} < (PSEL_W+1)'(PLAYERS));
    w_cur    = w_pvalid ? r_score[r_player] : '0;
    w_opd    = (r_op[r_k] > 4'd9) ? 4'd9 : r_op[r_k];
    w_sum    = {1'b0, w_cur[r_k]} + {1'b0, w_opd} + {4'b0, r_carry};
    w_cout   = (w_sum > 5'd9);
    w_digit  = w_cout ? 4'(w_sum - 5'd10) : w_sum[3:0];
    w_new    = r_carry ? {DIGITS{4'h9}} : r_work;
    w_life   = (w_new[DIGITS-1:LIFE_DIGIT] != w_cur[DIGITS-1:LIFE_DIGIT]);
    w_gt     = (w_new > r_hiscore);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_next = S_ADD;
      S_ADD:    if (r_k == K_W'(DIGITS-1)) w_state_next = S_COMMIT;
      S_COMMIT: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (clear) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_rr       <= '0;
      r_op       <= '0;
      r_player   <= '0;
      r_k        <= '0;
      r_carry    <= 1'b0;
      r_work     <= '0;
      r_score    <= '0;
      r_hiscore  <= '0;
      r_overflow <= '0;
      r_life     <= '0;
    end else begin
      r_life <= '0;
      if (clear) begin
        r_score    <= '0;
        r_overflow <= '0;
        r_k        <= '0;
        r_carry    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_op     <= add_value[w_gidx];
              r_player <= add_player[w_gidx];
              r_rr     <= w_rr_next;
              r_k      <= '0;
              r_carry  <= 1'b0;
            end
          end
          S_ADD: begin
            r_work[r_k] <= w_digit;
            r_carry     <= w_cout;
            r_k         <= r_k + K_W'(1);
          end
          S_COMMIT: begin
            if (w_pvalid) begin
              r_score[r_player] <= w_new;
              r_life[r_player]  <= w_life;
              if (r_carry) r_overflow[r_player] <= 1'b1;
              if (w_gt) r_hiscore <= w_new;
            end
          end
          default: ;
        endcase
      end
      // Placed last so a simultaneous commit cannot resurrect the old high score.
      if (hiscore_clr) begin
        r_hiscore <= '0;
      end
    end
  end

  assign score      = r_score;
  assign hiscore    = r_hiscore;
  assign overflow   = r_overflow;
  assign extra_life = r_life;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_score_accum.sv
// Bench for score_accum: directed scenarios plus randomized adds, checked against
// an integer-arithmetic model of the per-player scores.
module tb_score_accum;
  localparam int NUM_SRC    = 3;
  localparam int DIGITS     = 5;
  localparam int PLAYERS    = 2;
  localparam int LIFE_DIGIT = 4;
  localparam int PSEL_W     = 1;
  localparam int MAXV       = 99999;
  localparam int LIFE_UNIT  = 10000;

  logic                                clk = 1'b0;
  logic                                resetN;
  logic [NUM_SRC-1:0]                  add_valid;
  logic [NUM_SRC-1:0][DIGITS-1:0][3:0] add_value;
  logic [NUM_SRC-1:0][PSEL_W-1:0]      add_player;
  logic [NUM_SRC-1:0]                  add_ready;
  logic                                clear;
  logic                                hiscore_clr;
  logic [PLAYERS-1:0][DIGITS-1:0][3:0] score;
  logic [DIGITS-1:0][3:0]              hiscore;
  logic [PLAYERS-1:0]                  overflow;
  logic [PLAYERS-1:0]                  extra_life;
  logic                                busy;

  always #5 clk = ~clk;

  score_accum #(
    .NUM_SRC(NUM_SRC), .DIGITS(DIGITS), .PLAYERS(PLAYERS), .LIFE_DIGIT(LIFE_DIGIT)
  ) dut (
    .clk(clk), .resetN(resetN), .add_valid(add_valid), .add_value(add_value),
    .add_player(add_player), .add_ready(add_ready), .clear(clear),
    .hiscore_clr(hiscore_clr), .score(score), .hiscore(hiscore),
    .overflow(overflow), .extra_life(extra_life), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_score[PLAYERS];
  bit m_ovf[PLAYERS];
  int m_hi;
  int rr_m;
  bit m_life_exp;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int from_bcd(input logic [DIGITS*4-1:0] v);
    int r, w, d;
    r = 0; w = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'(v[k*4 +: 4]);
      if (d > 9) d = 9;
      r += d * w;
      w *= 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS*4-1:0] to_bcd(input int x);
    logic [DIGITS*4-1:0] v;
    v = '0;
    for (int k = 0; k < DIGITS; k++) begin
      v[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return v;
  endfunction

  task automatic model_add(input int p, input logic [DIGITS*4-1:0] v, input bit hclr);
    int old, nw;
    old = m_score[p];
    nw  = old + from_bcd(v);
    if (nw > MAXV) begin
      nw = MAXV;
      m_ovf[p] = 1'b1;
    end
    m_life_exp = ((nw / LIFE_UNIT) != (old / LIFE_UNIT));
    m_score[p] = nw;
    if (hclr) m_hi = 0;
    else if (nw > m_hi) m_hi = nw;
  endtask

  task automatic model_zero_scores();
    for (int p = 0; p < PLAYERS; p++) begin
      m_score[p] = 0;
      m_ovf[p]   = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [PLAYERS-1:0] eo;
    for (int p = 0; p < PLAYERS; p++) begin
      eo[p] = m_ovf[p];
      check_val($sformatf("%s_score%0d", tag, p), 32'(score[p]), 32'(to_bcd(m_score[p])));
    end
    check_val({tag, "_ovf"}, 32'(overflow), 32'(eo));
    check_val({tag, "_hi"}, 32'(hiscore), 32'(to_bcd(m_hi)));
  endtask

  // One complete add from a single source; called and returns at a falling edge.
  task automatic do_add(input int src, input logic [DIGITS*4-1:0] val, input int pl,
                        input bit hclr, input string tag);
    int t;
    logic [PLAYERS-1:0] el;
    add_value[src]  = val;
    add_player[src] = PSEL_W'(pl);
    add_valid[src]  = 1'b1;
    #1;
    check_val({tag, "_ready"}, 32'(add_ready), 32'(1 << src));
    t = 0;
    while (!add_ready[src] && t < 20) begin
      @(negedge clk); #1;
      t++;
    end
    if (!add_ready[src]) begin
      check_val({tag, "_accept_timeout"}, 32'(0), 32'(1));
      add_valid[src] = 1'b0;
      return;
    end
    rr_m = (src + 1) % NUM_SRC;
    @(posedge clk);
    @(negedge clk);
    add_valid[src] = 1'b0;
    check_val({tag, "_busy"}, 32'(busy), 32'(1));
    repeat (DIGITS) @(posedge clk);
    @(negedge clk);
    check_val({tag, "_untouched"}, 32'(score[pl]), 32'(to_bcd(m_score[pl])));
    hiscore_clr = hclr;
    @(posedge clk);
    @(negedge clk);
    hiscore_clr = 1'b0;
    model_add(pl, val, hclr);
    check_all(tag);
    el = '0;
    el[pl] = m_life_exp;
    check_val({tag, "_life"}, 32'(extra_life), 32'(el));
    check_val({tag, "_idle"}, 32'(busy), 32'(0));
    @(negedge clk);
    check_val({tag, "_life_off"}, 32'(extra_life), 32'(0));
  endtask

  initial begin
    #300us;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DIGITS*4-1:0] av[NUM_SRC];
    int                  ap[NUM_SRC];
    logic [DIGITS*4-1:0] rv;
    int grants, last, exp_g, nd, d;

    resetN = 1'b0; add_valid = '0; add_value = '0; add_player = '0;
    clear = 1'b0; hiscore_clr = 1'b0;
    model_zero_scores(); m_hi = 0; rr_m = 0;
    repeat (3) @(negedge clk);
    check_all("rst");
    check_val("rst_life", 32'(extra_life), 32'(0));
    check_val("rst_busy", 32'(busy), 32'(0));
    resetN = 1'b1;
    @(negedge clk);
    check_val("rst_ready", 32'(add_ready), 32'(0));
    check_all("rst_rel");

    do_add(0, 20'h00020, 0, 1'b0, "basic");
    do_add(1, 20'h09979, 0, 1'b0, "pre_carry");
    do_add(0, 20'h00001, 0, 1'b0, "carry");
    do_add(2, 20'h99990, 1, 1'b0, "ovf_pre");
    do_add(0, 20'h00020, 1, 1'b0, "ovf");
    do_add(1, 20'h00001, 1, 1'b0, "ovf_sticky");
    do_add(2, 20'h00000, 0, 1'b0, "add_zero");

    // All three sources held: grants rotate from the pointer, DIGITS+2 clocks apart.
    for (int s = 0; s < NUM_SRC; s++) begin
      av[s] = to_bcd($urandom_range(0, 3000));
      ap[s] = $urandom_range(0, PLAYERS - 1);
      add_value[s]  = av[s];
      add_player[s] = PSEL_W'(ap[s]);
    end
    add_valid = '1;
    grants = 0; last = 0;
    for (int c = 0; c < 60 && grants < 4; c++) begin
      #1;
      if (add_ready != '0) begin
        exp_g = rr_m;
        check_val($sformatf("arb_grant%0d", grants), 32'(add_ready), 32'(1 << exp_g));
        if (grants > 0) check_val($sformatf("arb_gap%0d", grants), 32'(c - last), 32'(DIGITS + 2));
        last = c;
        model_add(ap[exp_g], av[exp_g], 1'b0);
        rr_m = (exp_g + 1) % NUM_SRC;
        grants++;
      end
      @(negedge clk);
    end
    add_valid = '0;
    check_val("arb_count", 32'(grants), 32'(4));
    repeat (DIGITS + 1) @(posedge clk);
    @(negedge clk);
    check_all("arb_final");

    // clear during the third ADD clock drops the add and zeroes scores.
    add_value[1] = 20'h00300; add_player[1] = 1'b0; add_valid[1] = 1'b1;
    @(posedge clk);
    rr_m = 2;
    @(negedge clk);
    add_valid[1] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    add_value[0] = 20'h00007; add_player[0] = 1'b1; add_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_zero_scores();
    check_val("clr_busy", 32'(busy), 32'(0));
    check_val("clr_noready", 32'(add_ready), 32'(0));
    check_all("clr");
    clear = 1'b0;
    #1;
    check_val("clr_ready_after", 32'(add_ready), 32'(1));
    add_valid[0] = 1'b0;
    #1;
    check_val("withdraw_ready", 32'(add_ready), 32'(0));
    @(posedge clk);
    @(negedge clk);
    check_val("withdraw_busy", 32'(busy), 32'(0));

    do_add(2, 20'h01234, 1, 1'b1, "hclr");
    do_add(0, 20'h00011, 1, 1'b0, "hclr_after");

    for (int i = 0; i < 24; i++) begin
      rv = '0;
      nd = $urandom_range(1, 4);
      for (int k = 0; k < nd; k++) begin
        d = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
        rv[k*4 +: 4] = 4'(d);
      end
      do_add($urandom_range(0, NUM_SRC - 1), rv, $urandom_range(0, PLAYERS - 1),
             ($urandom_range(0, 5) == 0), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of an add.
    add_value[2] = 20'h00500; add_player[2] = 1'b0; add_valid[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    add_valid[2] = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    model_zero_scores(); m_hi = 0; rr_m = 0;
    check_all("arst");
    check_val("arst_busy", 32'(busy), 32'(0));
    check_val("arst_life", 32'(extra_life), 32'(0));
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    do_add(1, 20'h000C3, 0, 1'b0, "clamp");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
